// File: rtl/axi_lite_master_ctrl.sv
// ---------------------------------------------------------------------------
// axi_lite_master_ctrl
//
// Purpose:
//   Single-outstanding AXI-Lite master. A simple valid/ready command port is
//   turned into one AXI-Lite write (AW + W, then B) or one read (AR, then R).
//   The outcome is reported as a one-cycle rsp_valid pulse that carries the
//   read data and the BRESP/RRESP code. SLVERR and DECERR responses are
//   passed through as-is, and the transaction is never retried.
//
// Parameters:
//   ADDR_WIDTH  AXI-Lite address width (default 32)
//   DATA_WIDTH  data width, 32 or 64 (default 32)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready only when idle)
//   cmd_write                1 = write, 0 = read
//   cmd_addr / cmd_wdata / cmd_wstrb   command payload
//   rsp_valid                one-cycle completion pulse
//   rsp_data                 read data (0 after a write), held until the next completion
//   rsp_resp                 captured BRESP/RRESP, held until the next completion
//   busy                     a transaction is in flight
//   aw_* / w_* / b_*         AXI-Lite write address, write data and write response channels
//   ar_* / r_*               AXI-Lite read address and read data channels
// ---------------------------------------------------------------------------
module axi_lite_master_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]              rsp_resp,
  output logic                    busy,

  output logic [ADDR_WIDTH-1:0]   aw_addr,
  output logic                    aw_valid,
  input  logic                    aw_ready,

  output logic [DATA_WIDTH-1:0]   w_data,
  output logic [DATA_WIDTH/8-1:0] w_strb,
  output logic                    w_valid,
  input  logic                    w_ready,

  input  logic [1:0]              b_resp,
  input  logic                    b_valid,
  output logic                    b_ready,

  output logic [ADDR_WIDTH-1:0]   ar_addr,
  output logic                    ar_valid,
  input  logic                    ar_ready,

  input  logic [DATA_WIDTH-1:0]   r_data,
  input  logic [1:0]              r_resp,
  input  logic                    r_valid,
  output logic                    r_ready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] WRESP = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] RRESP = 3'd4;

  logic [2:0]            state;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  logic aw_done;
  logic w_done;

  logic cmd_accept;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic aw_fin;
  logic w_fin;
  logic write_fin;
  logic b_hs;
  logic r_hs;

  assign cmd_accept = (state == IDLE) && cmd_valid;
  assign aw_hs      = aw_valid && aw_ready;
  assign w_hs       = w_valid && w_ready;
  assign ar_hs      = ar_valid && ar_ready;

  // A channel counts as finished if it completed earlier (done flag) or is
  // completing this cycle. The write phase can therefore end in the same
  // cycle as the second handshake, whichever channel that is.
  assign aw_fin    = aw_done || aw_hs;
  assign w_fin     = w_done || w_hs;
  assign write_fin = (state == WRITE) && aw_fin && w_fin;

  // b_ready/r_ready are decoded from state. A stray b_valid/r_valid in any
  // other state can therefore never complete a handshake.
  assign b_ready = (state == WRESP);
  assign r_ready = (state == RRESP);
  assign b_hs    = b_ready && b_valid;
  assign r_hs    = r_ready && r_valid;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // One address register serves both AW and AR. Only one transaction is in
  // flight, so the two can never need different addresses at the same time.
  assign aw_addr = addr_q;
  assign ar_addr = addr_q;
  assign w_data  = wdata_q;
  assign w_strb  = wstrb_q;

  // Main transaction FSM. A write leaves WRITE only when both AW and W are
  // finished. Undefined encodings fall back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state <= cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (aw_fin && w_fin) begin
            state <= WRESP;
          end
        end
        WRESP: begin
          if (b_valid) begin
            state <= IDLE;
          end
        end
        READ: begin
          if (ar_hs) begin
            state <= RRESP;
          end
        end
        RRESP: begin
          if (r_valid) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The command payload is latched only on acceptance. It stays constant on
  // the AXI channels for the whole transaction, so it is stable while any
  // valid is waiting for its ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (cmd_accept) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
    end
  end

  // Request-channel valids are registered. They rise the cycle after the
  // command is accepted and fall the cycle after their own handshake, so
  // none of them depends combinationally on a ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_valid <= 1'b0;
      w_valid  <= 1'b0;
      ar_valid <= 1'b0;
    end else begin
      if (cmd_accept && cmd_write) begin
        aw_valid <= 1'b1;
      end else if (aw_hs) begin
        aw_valid <= 1'b0;
      end

      if (cmd_accept && cmd_write) begin
        w_valid <= 1'b1;
      end else if (w_hs) begin
        w_valid <= 1'b0;
      end

      if (cmd_accept && !cmd_write) begin
        ar_valid <= 1'b1;
      end else if (ar_hs) begin
        ar_valid <= 1'b0;
      end
    end
  end

  // The done flags record a channel that finished before its partner. They
  // clear when the write phase ends, so the next write starts from a clean state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (cmd_accept || write_fin) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == WRITE) begin
      if (aw_hs) begin
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        w_done <= 1'b1;
      end
    end
  end

  // Completion capture. rsp_valid is a one-cycle pulse in the first IDLE
  // cycle after the response handshake; that is also a cycle where
  // cmd_ready is high. rsp_data and rsp_resp hold until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      rsp_valid <= 1'b0;
      if (b_hs) begin
        rsp_valid <= 1'b1;
        rsp_data  <= '0;
        rsp_resp  <= b_resp;
      end else if (r_hs) begin
        rsp_valid <= 1'b1;
        rsp_data  <= r_data;
        rsp_resp  <= r_resp;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_master_ctrl
//
// Purpose:
//   Self-checking bench for axi_lite_master_ctrl. A table of directed
//   transactions is applied, and each record carries its hand-computed
//   response and latency. A few hand-written sequences cover back-to-back
//   commands, reset in the middle of a transaction and stray response valids.
//
// Timing:
//   The bench acts 1 ns after each falling edge. The slave model acts on the
//   falling edge itself, so every DUT output is sampled away from the rising edge.
// ---------------------------------------------------------------------------
module tb_axi_lite_master_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct {
    logic          write;
    logic          tie;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    int            aw_d;
    int            w_d;
    int            ar_d;
    int            rsp_d;
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_resp;
    int            exp_lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;

  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_resp;
  logic          busy;

  logic [AW-1:0] aw_addr;
  logic          aw_valid;
  logic          aw_ready = 1'b0;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic          w_valid;
  logic          w_ready = 1'b0;
  logic [1:0]    b_resp;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] ar_addr;
  logic          ar_valid;
  logic          ar_ready = 1'b0;
  logic [DW-1:0] r_data;
  logic [1:0]    r_resp;
  logic          r_valid;
  logic          r_ready;

  // slave configuration, written by the main sequence
  int            aw_d = 0;
  int            w_d  = 0;
  int            ar_d = 0;
  int            b_d  = 0;
  int            r_d  = 0;
  logic          tie  = 1'b0;
  logic [1:0]    b_resp_cfg = 2'b00;
  logic [1:0]    r_resp_cfg = 2'b00;
  logic [DW-1:0] r_data_cfg = '0;
  logic          stray_b = 1'b0;
  logic          stray_r = 1'b0;

  // slave state and captured channel payloads
  logic          b_auto = 1'b0;
  logic          r_auto = 1'b0;
  int            aw_cnt = 0;
  int            w_cnt  = 0;
  int            ar_cnt = 0;
  int            b_cnt  = 0;
  int            r_cnt  = 0;
  logic [AW-1:0] cap_awaddr = '0;
  logic [DW-1:0] cap_wdata  = '0;
  logic [SW-1:0] cap_wstrb  = '0;
  logic [AW-1:0] cap_araddr = '0;
  int            aw_hs_n = 0;
  int            w_hs_n  = 0;
  int            ar_hs_n = 0;

  // monitor state
  logic          prev_aw_valid = 1'b0;
  logic          prev_w_valid  = 1'b0;
  logic          prev_ar_valid = 1'b0;
  logic          prev_rsp_valid = 1'b0;
  logic [AW-1:0] prev_aw_addr = '0;
  logic [DW-1:0] prev_w_data  = '0;
  logic [SW-1:0] prev_w_strb  = '0;
  logic [AW-1:0] prev_ar_addr = '0;

  int            total = 0;
  int            passed = 0;
  int            viol = 0;
  int            rsp_count = 0;

  vec_t          vecs [7];

  assign b_valid = stray_b | b_auto;
  assign r_valid = stray_r | r_auto;
  assign b_resp  = b_resp_cfg;
  assign r_resp  = r_resp_cfg;
  assign r_data  = r_data_cfg;

  always #5 clk = ~clk;

  axi_lite_master_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_resp  (rsp_resp),
    .busy      (busy),
    .aw_addr   (aw_addr),
    .aw_valid  (aw_valid),
    .aw_ready  (aw_ready),
    .w_data    (w_data),
    .w_strb    (w_strb),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .b_resp    (b_resp),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .ar_addr   (ar_addr),
    .ar_valid  (ar_valid),
    .ar_ready  (ar_ready),
    .r_data    (r_data),
    .r_resp    (r_resp),
    .r_valid   (r_valid),
    .r_ready   (r_ready)
  );

  // Protocol monitor and slave model. The monitor runs first and uses the
  // readys the DUT saw at the previous rising edge. The slave then sets the
  // readys and response valids for the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      aw_ready = 1'b0;
      w_ready  = 1'b0;
      ar_ready = 1'b0;
      b_auto   = 1'b0;
      r_auto   = 1'b0;
      aw_cnt = 0;
      w_cnt  = 0;
      ar_cnt = 0;
      b_cnt  = 0;
      r_cnt  = 0;
      prev_aw_valid  = 1'b0;
      prev_w_valid   = 1'b0;
      prev_ar_valid  = 1'b0;
      prev_rsp_valid = 1'b0;
    end else begin
      if (prev_aw_valid && !aw_ready && (!aw_valid || aw_addr !== prev_aw_addr)) begin
        viol++;
        $display("[TB] FAIL protocol aw_hold at %0t: aw_valid=%0b aw_addr=0x%0h, required 1 / 0x%0h",
                 $time, aw_valid, aw_addr, prev_aw_addr);
      end
      if (prev_w_valid && !w_ready &&
          (!w_valid || w_data !== prev_w_data || w_strb !== prev_w_strb)) begin
        viol++;
        $display("[TB] FAIL protocol w_hold at %0t: w_valid=%0b w_data=0x%0h, required 1 / 0x%0h",
                 $time, w_valid, w_data, prev_w_data);
      end
      if (prev_ar_valid && !ar_ready && (!ar_valid || ar_addr !== prev_ar_addr)) begin
        viol++;
        $display("[TB] FAIL protocol ar_hold at %0t: ar_valid=%0b ar_addr=0x%0h, required 1 / 0x%0h",
                 $time, ar_valid, ar_addr, prev_ar_addr);
      end
      if (ar_valid && (aw_valid || w_valid)) begin
        viol++;
        $display("[TB] FAIL protocol mixed_valids at %0t: ar_valid=1 with aw_valid=%0b w_valid=%0b, required none",
                 $time, aw_valid, w_valid);
      end
      if ((b_ready || r_ready) &&
          ((b_ready && r_ready) || aw_valid || w_valid || ar_valid || !busy)) begin
        viol++;
        $display("[TB] FAIL protocol resp_ready at %0t: b_ready=%0b r_ready=%0b busy=%0b, required exclusive ready",
                 $time, b_ready, r_ready, busy);
      end
      if (cmd_ready === busy) begin
        viol++;
        $display("[TB] FAIL protocol ready_busy at %0t: cmd_ready=%0b busy=%0b, required complementary",
                 $time, cmd_ready, busy);
      end
      if (rsp_valid && prev_rsp_valid) begin
        viol++;
        $display("[TB] FAIL protocol rsp_width at %0t: rsp_valid high 2 cycles, required 1", $time);
      end
      if (rsp_valid) begin
        rsp_count++;
      end
      prev_aw_valid  = aw_valid;
      prev_w_valid   = w_valid;
      prev_ar_valid  = ar_valid;
      prev_rsp_valid = rsp_valid;
      prev_aw_addr   = aw_addr;
      prev_w_data    = w_data;
      prev_w_strb    = w_strb;
      prev_ar_addr   = ar_addr;

      if (tie) begin
        aw_ready = 1'b1;
      end else if (aw_valid) begin
        aw_ready = (aw_cnt >= aw_d);
        aw_cnt++;
      end else begin
        aw_ready = 1'b0;
        aw_cnt = 0;
      end
      if (tie) begin
        w_ready = 1'b1;
      end else if (w_valid) begin
        w_ready = (w_cnt >= w_d);
        w_cnt++;
      end else begin
        w_ready = 1'b0;
        w_cnt = 0;
      end
      if (tie) begin
        ar_ready = 1'b1;
      end else if (ar_valid) begin
        ar_ready = (ar_cnt >= ar_d);
        ar_cnt++;
      end else begin
        ar_ready = 1'b0;
        ar_cnt = 0;
      end
      if (aw_valid && aw_ready) begin
        cap_awaddr = aw_addr;
        aw_hs_n++;
      end
      if (w_valid && w_ready) begin
        cap_wdata = w_data;
        cap_wstrb = w_strb;
        w_hs_n++;
      end
      if (ar_valid && ar_ready) begin
        cap_araddr = ar_addr;
        ar_hs_n++;
      end

      if (b_ready) begin
        b_auto = (b_cnt >= b_d);
        b_cnt++;
      end else begin
        b_auto = 1'b0;
        b_cnt = 0;
      end
      if (r_ready) begin
        r_auto = (r_cnt >= r_d);
        r_cnt++;
      end else begin
        r_auto = 1'b0;
        r_cnt = 0;
      end
    end
  end

  // Hard stop in case the sequence itself goes wrong
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Apply one table record. Latency is counted in cycles from the cycle the
  // command is presented (N) to the cycle rsp_valid is seen.
  task automatic applyStimulus(input vec_t v, input string tag);
    int  lat;
    bit  seen;
    int  rsp0;
    int  aw0;
    int  w0;
    int  ar0;
    logic [DW-1:0] held_data;

    tie        = v.tie;
    aw_d       = v.aw_d;
    w_d        = v.w_d;
    ar_d       = v.ar_d;
    b_d        = v.rsp_d;
    r_d        = v.rsp_d;
    b_resp_cfg = v.resp;
    r_resp_cfg = v.resp;
    r_data_cfg = v.rdata;

    checkOutput({tag, ".cmd_ready_idle"}, cmd_ready, 1'b1);
    rsp0 = rsp_count;
    aw0  = aw_hs_n;
    w0   = w_hs_n;
    ar0  = ar_hs_n;

    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_wstrb = v.wstrb;

    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (lat == 1) begin
        cmd_valid = 1'b0;
      end
      if (rsp_valid) begin
        seen = 1'b1;
      end
    end

    checkOutput({tag, ".rsp_seen"}, seen, 1'b1);
    checkOutput({tag, ".latency"}, lat, v.exp_lat);
    checkOutput({tag, ".rsp_data"}, rsp_data, v.exp_data);
    checkOutput({tag, ".rsp_resp"}, rsp_resp, v.exp_resp);
    checkOutput({tag, ".cmd_ready_at_rsp"}, cmd_ready, 1'b1);
    held_data = rsp_data;

    tick();
    checkOutput({tag, ".rsp_pulse_width"}, rsp_valid, 1'b0);
    checkOutput({tag, ".rsp_data_hold"}, rsp_data, held_data);
    checkOutput({tag, ".busy_after"}, busy, 1'b0);
    checkOutput({tag, ".rsp_count"}, rsp_count - rsp0, 1);
    if (v.write) begin
      checkOutput({tag, ".aw_addr"}, cap_awaddr, v.addr);
      checkOutput({tag, ".w_data"}, cap_wdata, v.wdata);
      checkOutput({tag, ".w_strb"}, cap_wstrb, v.wstrb);
      checkOutput({tag, ".aw_hs_count"}, aw_hs_n - aw0, 1);
      checkOutput({tag, ".w_hs_count"}, w_hs_n - w0, 1);
      checkOutput({tag, ".ar_hs_count"}, ar_hs_n - ar0, 0);
    end else begin
      checkOutput({tag, ".ar_addr"}, cap_araddr, v.addr);
      checkOutput({tag, ".ar_hs_count"}, ar_hs_n - ar0, 1);
      checkOutput({tag, ".aw_hs_count"}, aw_hs_n - aw0, 0);
    end
    tie = 1'b0;
  endtask

  initial begin
    int   lat;
    bit   seen;
    bit   any;
    int   rsp0;
    vec_t rv;

    // write  tie addr      wdata         strb  awd wd ard rspd resp   rdata         exp_data      exp_resp lat
    vecs[0] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        2'b00, 3};
    vecs[1] = '{1'b1, 1'b0, 32'h14, 32'hCAFEF00D, 4'h3, 0, 3, 0, 0, 2'b00, 32'h0,        32'h0,        2'b00, 6};
    vecs[2] = '{1'b1, 1'b0, 32'h18, 32'h01020304, 4'hC, 2, 0, 0, 1, 2'b10, 32'h0,        32'h0,        2'b10, 6};
    vecs[3] = '{1'b0, 1'b0, 32'h20, 32'h0,        4'h0, 0, 0, 0, 4, 2'b10, 32'h12345678, 32'h12345678, 2'b10, 7};
    vecs[4] = '{1'b0, 1'b0, 32'h24, 32'h0,        4'h0, 0, 0, 2, 0, 2'b11, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b11, 5};
    vecs[5] = '{1'b1, 1'b0, 32'h28, 32'h89ABCDEF, 4'h5, 1, 1, 0, 0, 2'b11, 32'h77777777, 32'h0,        2'b11, 4};
    vecs[6] = '{1'b0, 1'b1, 32'h00, 32'h0,        4'h0, 0, 0, 0, 0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 3};

    $display("[TB] reset phase");
    tick();
    tick();
    checkOutput("reset.busy", busy, 1'b0);
    checkOutput("reset.cmd_ready", cmd_ready, 1'b1);
    checkOutput("reset.valids", {aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid}, 6'b0);
    checkOutput("reset.rsp_data", rsp_data, 32'h0);
    checkOutput("reset.rsp_resp", rsp_resp, 2'b00);
    rst = 1'b0;
    tick();

    $display("[TB] table-driven transactions");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: write then read, with cmd_valid never dropped
    $display("[TB] back-to-back write then read");
    aw_d = 0; w_d = 0; ar_d = 0; b_d = 0; r_d = 0;
    b_resp_cfg = 2'b01;
    r_resp_cfg = 2'b00;
    r_data_cfg = 32'h55667788;
    rsp0 = rsp_count;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h30;
    cmd_wdata = 32'h11112222;
    cmd_wstrb = 4'hF;
    tick();
    cmd_write = 1'b0;
    cmd_addr  = 32'h34;
    lat  = 1;
    seen = rsp_valid;
    while (!seen && lat < 20) begin
      tick();
      lat++;
      seen = rsp_valid;
    end
    checkOutput("b2b.first_rsp_seen", seen, 1'b1);
    checkOutput("b2b.first_latency", lat, 3);
    checkOutput("b2b.cmd_ready_at_rsp", cmd_ready, 1'b1);
    checkOutput("b2b.first_rsp_resp", rsp_resp, 2'b01);
    checkOutput("b2b.first_rsp_data", rsp_data, 32'h0);
    tick();
    checkOutput("b2b.second_accepted_in_rsp_cycle", {busy, ar_valid}, 2'b11);
    cmd_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      tick();
      lat++;
      seen = rsp_valid;
    end
    checkOutput("b2b.second_rsp_seen", seen, 1'b1);
    checkOutput("b2b.second_latency", lat, 3);
    checkOutput("b2b.second_rsp_data", rsp_data, 32'h55667788);
    checkOutput("b2b.second_rsp_resp", rsp_resp, 2'b00);
    checkOutput("b2b.ar_addr", cap_araddr, 32'h34);
    tick();
    checkOutput("b2b.rsp_count", rsp_count - rsp0, 2);

    // Reset asserted while waiting in WRESP
    $display("[TB] reset during write response");
    b_d = 20;
    b_resp_cfg = 2'b00;
    rsp0 = rsp_count;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h40;
    cmd_wdata = 32'hFEEDFACE;
    cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    while (!b_ready && lat < 10) begin
      tick();
      lat++;
    end
    checkOutput("rstwr.reached_wresp", b_ready, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("rstwr.valids_low", {aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, busy}, 7'b0);
    checkOutput("rstwr.cmd_ready", cmd_ready, 1'b1);
    checkOutput("rstwr.rsp_data", rsp_data, 32'h0);
    checkOutput("rstwr.rsp_resp", rsp_resp, 2'b00);
    checkOutput("rstwr.addr_data_regs", {aw_addr, w_data}, 64'h0);
    tick();
    tick();
    rst = 1'b0;
    b_d = 0;
    tick();
    checkOutput("rstwr.no_rsp", rsp_count - rsp0, 0);
    rv = '{1'b0, 1'b0, 32'h44, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 32'h0BADF00D, 32'h0BADF00D, 2'b00, 3};
    applyStimulus(rv, "rstwr.read");

    // Stray b_valid / r_valid while idle, and a stray b_valid during READ
    $display("[TB] stray response valids");
    rsp0 = rsp_count;
    b_resp_cfg = 2'b11;
    stray_b = 1'b1;
    stray_r = 1'b1;
    any = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      any = any | rsp_valid | busy | b_ready | r_ready;
    end
    stray_b = 1'b0;
    stray_r = 1'b0;
    checkOutput("stray.idle_ignored", any, 1'b0);
    tick();
    checkOutput("stray.idle_rsp_count", rsp_count - rsp0, 0);

    ar_d = 2;
    r_d  = 1;
    r_resp_cfg = 2'b00;
    r_data_cfg = 32'h600DCAFE;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h50;
    tick();
    cmd_valid = 1'b0;
    stray_b = 1'b1;
    tick();
    checkOutput("stray.read_state_kept", {busy, ar_valid, b_ready, rsp_valid}, 4'b1100);
    stray_b = 1'b0;
    lat  = 2;
    seen = 1'b0;
    while (!seen && lat < 30) begin
      tick();
      lat++;
      seen = rsp_valid;
    end
    checkOutput("stray.read_rsp_seen", seen, 1'b1);
    checkOutput("stray.read_latency", lat, 6);
    checkOutput("stray.read_rsp_data", rsp_data, 32'h600DCAFE);
    checkOutput("stray.read_rsp_resp", rsp_resp, 2'b00);
    tick();
    checkOutput("stray.read_rsp_count", rsp_count - rsp0, 1);

    tick();
    tick();
    checkOutput("protocol.violations", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_ctrl.md
AXI_LITE_MASTER_CTRL -- requirements
Module: axi_lite_master_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: AXI-Lite address width.
REQ-002 Parameter DATA_WIDTH, default 32: data width; SHALL be 32 or 64.
REQ-003 The block SHALL use one clock, clk; reset rst is asynchronous and active-high.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write strobes
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  captured BRESP/RRESP
- busy  out  1  transaction in flight
- aw_addr  out  ADDR_WIDTH  write address
- aw_valid  out  1  write address valid
- aw_ready  in  1  write address ready
- w_data  out  DATA_WIDTH  write data
- w_strb  out  DATA_WIDTH/8  write strobes
- w_valid  out  1  write data valid
- w_ready  in  1  write data ready
- b_resp  in  2  write response
- b_valid  in  1  write response valid
- b_ready  out  1  write response ready
- ar_addr  out  ADDR_WIDTH  read address
- ar_valid  out  1  read address valid
- ar_ready  in  1  read address ready
- r_data  in  DATA_WIDTH  read data
- r_resp  in  2  read response
- r_valid  in  1  read data valid
- r_ready  out  1  read data ready

Function
REQ-005 The FSM SHALL have states IDLE, WRITE, WRESP, READ, RRESP, with one transaction outstanding at most.
REQ-006 cmd_ready = (state == IDLE); busy = (state != IDLE); both decoded from state only.
REQ-007 IDLE, on cmd_valid: register addr/wdata/wstrb; go to WRITE if cmd_write, else READ. aw_valid/w_valid or ar_valid SHALL be high in the next cycle.
REQ-008 WRITE: aw_valid and w_valid SHALL be asserted independently.
- Each drops the cycle after its own handshake; an aw_done/w_done flag is set.
- Go to WRESP when both are done, including same-cycle completion.
- Handshake order (AW first, W first, or simultaneous) SHALL NOT matter.
REQ-009 WRESP: b_ready = 1. On b_valid, capture b_resp into rsp_resp, set rsp_data = 0, pulse rsp_valid next cycle, return to IDLE.
REQ-010 READ: ar_valid held until ar_ready, then go to RRESP.
REQ-011 RRESP: r_ready = 1. On r_valid, capture r_data/r_resp, pulse rsp_valid next cycle, return to IDLE.
REQ-012 Once asserted, a valid SHALL stay high with address/data/strobe stable until its handshake; no valid depends combinationally on a ready.
REQ-013 b_ready/r_ready SHALL be high only in WRESP/RRESP respectively. Stray b_valid/r_valid in other states SHALL be ignored.
REQ-014 rsp_valid SHALL be exactly one cycle wide. rsp_data/rsp_resp hold until the next completion.
REQ-015 cmd_ready SHALL be high in the cycle rsp_valid pulses, so back-to-back commands are allowed.
REQ-016 Minimum latency with all slave readys high and zero-wait responses:
- cmd accepted cycle N; AW/W or AR handshake N+1; B/R handshake N+2; rsp_valid N+3.
REQ-017 Response codes SHALL pass through unmodified; no retry on SLVERR/DECERR.

Reset
REQ-018 While rst is high: state = IDLE, aw_valid/w_valid/ar_valid/b_ready/r_ready/rsp_valid/busy = 0, done flags cleared, rsp_data/rsp_resp/address/data registers = 0.
REQ-019 Reset mid-transaction SHALL abort immediately to IDLE with no rsp_valid; the first command after rst deasserts SHALL be handled normally.

Verification
REQ-020 Write, readys tied high: cmd addr 0x10, data 0xDEADBEEF, strb 0xF -> aw/w handshake in 1 cycle, b_resp 00, rsp_valid at N+3, rsp_resp 00, rsp_data 0.
REQ-021 Write, w_ready delayed 3 cycles after aw_ready -> aw_valid drops after its handshake, w_valid held 3 extra cycles with stable data, exactly one rsp_valid.
REQ-022 Read 0x20, slave returns 0x12345678 with RRESP 10 after 4 wait cycles -> rsp_data 0x12345678, rsp_resp 10, r_ready high only in RRESP.
REQ-023 Back-to-back write then read with cmd_valid held -> second cmd accepted in the rsp_valid cycle; no cycle with two valids from different transactions.
REQ-024 rst asserted in WRESP before b_valid -> all outputs 0 and no rsp_valid; next read completes correctly.
REQ-025 b_valid pulsed during IDLE and READ -> ignored; no rsp_valid and no state change.
